issue_station: RTL and testbench



---
 rtl/issue_station.sv | 119 +++++++++++
 tb/tb_issue_station.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_station.sv
// In-order issue front end: a small micro-op FIFO feeding an IS stage (register
// read addresses) and an EX stage (ALU opcode and write-back enables).
module issue_station #(
  parameter int DEPTH = 4,
  parameter int OPW   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           in_op,
  input  logic [2:0]               in_a,
  input  logic [2:0]               in_b,
  input  logic [2:0]               in_d,
  input  logic                     in_d_wr,
  input  logic                     in_sf_wr,
  input  logic [15:0]              in_pc,
  input  logic                     stall,
  input  logic                     flush,
  output logic [2:0]               r_a_addr,
  output logic [2:0]               r_b_addr,
  output logic [15:0]              r_pc,
  output logic [OPW-1:0]           alu_op,
  output logic                     alu_d_wr,
  output logic [2:0]               alu_d_adr,
  output logic                     alu_sf_wr,
  output logic                     ex_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [2:0]     a;
    logic [2:0]     b;
    logic [2:0]     d;
    logic           d_wr;
    logic           sf_wr;
    logic [15:0]    pc;
  } uop_t;

  uop_t          mem [DEPTH];
  uop_t          in_uop;
  uop_t          is_q, ex_q;
  logic          is_v, ex_v;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          push, pop, advance;

  assign in_uop = '{op: in_op, a: in_a, b: in_b, d: in_d,
                    d_wr: in_d_wr, sf_wr: in_sf_wr, pc: in_pc};

  // Full is judged on the current occupancy only; a same-cycle pop does not open a slot.
  assign in_ready = !rst && !flush && (cnt < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign advance  = !stall && !flush;
  assign pop      = advance && (cnt != '0);

  // NOTE: the payload array has no reset; occupancy and pointers alone define
  // which entries are meaningful, so clearing storage would only cost area.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_uop;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; EX must capture the old IS, not the freshly popped head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      is_q   <= '0;
      is_v   <= 1'b0;
      ex_q   <= '0;
      ex_v   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      is_q   <= '0;
      is_v   <= 1'b0;
      ex_q   <= '0;
      ex_v   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
      if (advance) begin
        ex_q <= is_q;
        ex_v <= is_v;
        is_q <= pop ? mem[rd_ptr] : '0;
        is_v <= pop;
      end
    end
  end

  // While stalled the register file keeps re-reading EX's operands so they are
  // still valid on the release cycle, when IS's operands take over.
  always_comb begin
    r_a_addr = is_q.a;
    r_b_addr = is_q.b;
    r_pc     = is_q.pc;
    if (stall) begin
      r_a_addr = ex_q.a;
      r_b_addr = ex_q.b;
      r_pc     = ex_q.pc;
    end
  end

  assign alu_op    = ex_q.op;
  assign alu_d_adr = ex_q.d;
  assign alu_d_wr  = ex_v && ex_q.d_wr  && advance;
  assign alu_sf_wr = ex_v && ex_q.sf_wr && advance;
  assign ex_valid  = ex_v;
  assign count     = cnt;

endmodule

// File: tb/tb_issue_station.sv
// Self-checking bench for issue_station: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model.
module tb_issue_station;

  localparam int DEPTH = 4;
  localparam int OPW   = 6;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [2:0]     a;
    logic [2:0]     b;
    logic [2:0]     d;
    logic           d_wr;
    logic           sf_wr;
    logic [15:0]    pc;
  } uop_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready;
  logic [OPW-1:0] in_op;
  logic [2:0]     in_a, in_b, in_d;
  logic           in_d_wr, in_sf_wr;
  logic [15:0]    in_pc;
  logic           stall, flush;
  logic [2:0]     r_a_addr, r_b_addr;
  logic [15:0]    r_pc;
  logic [OPW-1:0] alu_op;
  logic           alu_d_wr, alu_sf_wr, ex_valid;
  logic [2:0]     alu_d_adr;
  logic [$clog2(DEPTH):0] count;

  issue_station #(.DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_d(in_d),
    .in_d_wr(in_d_wr), .in_sf_wr(in_sf_wr), .in_pc(in_pc),
    .stall(stall), .flush(flush),
    .r_a_addr(r_a_addr), .r_b_addr(r_b_addr), .r_pc(r_pc),
    .alu_op(alu_op), .alu_d_wr(alu_d_wr), .alu_d_adr(alu_d_adr),
    .alu_sf_wr(alu_sf_wr), .ex_valid(ex_valid), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue for the FIFO plus two pipeline slots.
  uop_t q[$];
  uop_t m_is, m_ex;
  bit   m_is_v, m_ex_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic uop_t cur_in();
    return '{op: in_op, a: in_a, b: in_b, d: in_d, d_wr: in_d_wr, sf_wr: in_sf_wr, pc: in_pc};
  endfunction

  task automatic set_op(input logic v, input logic [OPW-1:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, input logic dwr,
                        input logic sfwr, input logic [15:0] pc);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_d = d;
    in_d_wr = dwr; in_sf_wr = sfwr; in_pc = pc;
  endtask

  task automatic model_clear();
    q.delete();
    m_is = '0; m_is_v = 1'b0;
    m_ex = '0; m_ex_v = 1'b0;
  endtask

  task automatic compare_all();
    uop_t sel;
    bit   go;
    go  = !stall && !flush;
    sel = stall ? m_ex : m_is;
    check("in_ready",  in_ready,  32'(!flush && q.size() < DEPTH));
    check("count",     count,     q.size());
    check("ex_valid",  ex_valid,  m_ex_v);
    check("alu_op",    alu_op,    m_ex.op);
    check("alu_d_adr", alu_d_adr, m_ex.d);
    check("alu_d_wr",  alu_d_wr,  32'(m_ex_v && m_ex.d_wr && go));
    check("alu_sf_wr", alu_sf_wr, 32'(m_ex_v && m_ex.sf_wr && go));
    check("r_a_addr",  r_a_addr,  sel.a);
    check("r_b_addr",  r_b_addr,  sel.b);
    check("r_pc",      r_pc,      sel.pc);
  endtask

  task automatic model_edge();
    bit push;
    if (flush) begin
      model_clear();
    end else begin
      push = in_valid && (q.size() < DEPTH);
      if (!stall) begin
        m_ex = m_is; m_ex_v = m_is_v;
        if (q.size() > 0) begin
          m_is = q.pop_front(); m_is_v = 1'b1;
        end else begin
          m_is = '0; m_is_v = 1'b0;
        end
      end
      if (push) q.push_back(cur_in());
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    set_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit accepted;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    model_clear();
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_count",    count,    0);
    check("rst_r_pc",     r_pc,     0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Single op latency: visible at IS after 2 edges, write-back on the 3rd for one cycle.
    set_op(1'b1, 6'h15, 3'd1, 3'd2, 3'd4, 1'b1, 1'b0, 16'h1234);
    step();
    set_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    step();
    #1;
    check("lat_r_a", r_a_addr, 1);
    check("lat_r_b", r_b_addr, 2);
    check("lat_r_pc", r_pc, 16'h1234);
    check("lat_wr_early", alu_d_wr, 0);
    step();
    #1;
    check("lat_wr", alu_d_wr, 1);
    check("lat_d_adr", alu_d_adr, 4);
    check("lat_op", alu_op, 6'h15);
    step();
    #1;
    check("lat_wr_once", alu_d_wr, 0);
    idle(2);

    // Full FIFO under stall: four accepted, fifth held off until release.
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_op(1'b1, 6'(k + 1), 3'(k), 3'(k + 1), 3'(k + 2), 1'b1, k[0], 16'(16'h100 + k));
      step();
    end
    #1;
    check("full_count", count, 4);
    check("full_ready", in_ready, 0);
    stall = 1'b0;
    accepted = 1'b0;
    for (int t = 0; t < 10 && !accepted; t++) begin
      #1;
      accepted = in_ready;
      step();
    end
    check("fifth_accepted", accepted, 1);
    idle(8);

    // Operand mux while stalled: X in EX, Y in IS.
    set_op(1'b1, 6'h2a, 3'd5, 3'd3, 3'd7, 1'b1, 1'b1, 16'hAAAA);
    step();
    set_op(1'b1, 6'h11, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 16'hBBBB);
    step();
    set_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    step();
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("stall_r_a", r_a_addr, 5);
      check("stall_r_pc", r_pc, 16'hAAAA);
      check("stall_no_wr", alu_d_wr, 0);
      step();
    end
    stall = 1'b0;
    #1;
    check("rel_r_a", r_a_addr, 6);
    check("rel_wr", alu_d_wr, 1);
    check("rel_sf", alu_sf_wr, 1);
    step();
    #1;
    check("rel_wr_once", alu_d_wr, 0);
    idle(3);

    // Flush with IS/EX valid and three queued ops.
    for (int k = 0; k < 3; k++) begin
      set_op(1'b1, 6'(k + 9), 3'(k), 3'(k), 3'(k + 1), 1'b1, 1'b1, 16'(k + 16'h200));
      step();
    end
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_op(1'b1, 6'(k + 20), 3'(k), 3'(k), 3'(k), 1'b1, 1'b1, 16'(k + 16'h300));
      step();
    end
    #1;
    check("pre_flush_count", count, 3);
    flush = 1'b1; stall = 1'b0;
    set_op(1'b1, 6'h3f, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 16'hFFFF);
    #1;
    check("flush_no_wr", alu_d_wr, 0);
    check("flush_ready", in_ready, 0);
    step();
    flush = 1'b0;
    set_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    check("post_flush_count", count, 0);
    check("post_flush_ex", ex_valid, 0);
    idle(3);

    // Continuous stream of 9 ops exercising pointer wrap.
    for (int k = 0; k < 9; k++) begin
      set_op(1'b1, 6'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             1'b1, 1'($urandom), 16'($urandom));
      step();
    end
    idle(4);

    // Mid-stream reset.
    for (int k = 0; k < 4; k++) begin
      stall = (k >= 2);
      set_op(1'b1, 6'(k + 1), 3'(k), 3'(k), 3'(k), 1'b1, 1'b1, 16'(k));
      step();
    end
    rst = 1'b1;
    #1;
    model_clear();
    check("mid_rst_count", count, 0);
    check("mid_rst_ex", ex_valid, 0);
    check("mid_rst_wr", alu_d_wr, 0);
    check("mid_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    check("mid_rst_ready_hold", in_ready, 0);
    rst = 1'b0;
    stall = 1'b0;
    set_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    check("mid_rst_ready_after", in_ready, 1);
    idle(2);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      set_op($urandom_range(0, 9) < 7, 6'($urandom), 3'($urandom), 3'($urandom),
             3'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
